// File: rtl/sync_lock_counter_if.sv
// Sync/counter bundle between a sync source (master) and sync_lock_counter (slave).
// Signal names mirror the block's pin names so both sides read the same.
interface sync_lock_counter_if #(
  parameter int CNT_WIDTH   = 10,
  parameter int FRAME_WIDTH = 8
);
  logic                   i_HSync;
  logic                   i_VSync;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [CNT_WIDTH-1:0]   o_Col_Count;
  logic [CNT_WIDTH-1:0]   o_Row_Count;
  logic                   o_Active;
  logic                   o_Frame_Start;
  logic [FRAME_WIDTH-1:0] o_Frame_Count;
  logic                   o_Locked;
  logic                   o_Sync_Err;

  // Sync source side: drives the raw syncs, observes the regenerated timing.
  modport master (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Frame_Count, o_Locked, o_Sync_Err
  );

  // Counter block side.
  modport slave (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Frame_Count, o_Locked, o_Sync_Err
  );
endinterface

// File: rtl/sync_lock_counter.sv
// Regenerates row/column counters from incoming HSync/VSync, re-registers the
// syncs to line up with the counters, and tracks whether the incoming frame
// timing is stable (lock FSM) with an error pulse on every alignment fault.
module sync_lock_counter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CNT_WIDTH   = 10,
  parameter int FRAME_WIDTH = 8,
  parameter bit VSYNC_RISE  = 1'b1,
  parameter int LOCK_FRAMES = 3,
  parameter int UNLOCK_ERRS = 2
) (
  input  logic               clk,
  input  logic               i_Rst,
  sync_lock_counter_if.slave io_sync
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(TOTAL_COLS - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [CNT_WIDTH:0]   ACT_COLS   = (CNT_WIDTH+1)'(ACTIVE_COLS);
  localparam logic [CNT_WIDTH:0]   ACT_ROWS   = (CNT_WIDTH+1)'(ACTIVE_ROWS);
  // Thresholds are "one before the target" so the counters never need to hold
  // the target itself (keeps LOCK_FRAMES=1 / UNLOCK_ERRS=1 well defined).
  localparam logic [GOOD_W-1:0]    GOOD_LAST  = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [ERR_W-1:0]     ERRS_LAST  = ERR_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Registered state
  logic                   r_hsync;
  logic                   r_vsync;
  logic [CNT_WIDTH-1:0]   r_col;
  logic [CNT_WIDTH-1:0]   r_row;
  logic                   r_active;
  logic                   r_frame_start;
  logic [FRAME_WIDTH-1:0] r_frame_cnt;
  state_t                 r_state;
  logic [GOOD_W-1:0]      r_good;
  logic [ERR_W-1:0]       r_errs;
  logic                   r_locked;
  logic                   r_sync_err;

  // Combinational terms
  logic                   w_edge;
  logic                   w_wrap;
  logic                   w_aligned;
  logic                   w_misaligned;
  logic                   w_missing;
  logic [CNT_WIDTH-1:0]   w_col_next;
  logic [CNT_WIDTH-1:0]   w_row_next;
  logic                   w_active_next;
  state_t                 w_state_next;
  logic [GOOD_W-1:0]      w_good_next;
  logic [ERR_W-1:0]       w_errs_next;
  logic                   w_err_pulse;

  // Frame-start edge is taken against the re-registered sync so the counters
  // reload on the same edge that o_VSync first shows the post-edge level.
  assign w_edge       = VSYNC_RISE ? (~r_vsync & io_sync.i_VSync)
                                   : (r_vsync & ~io_sync.i_VSync);
  assign w_wrap       = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_aligned    = w_edge & w_wrap;
  assign w_misaligned = w_edge & ~w_wrap;
  assign w_missing    = w_wrap & ~w_edge;

  // Next counter position: reload on a frame start, otherwise raster-scan.
  always_comb begin
    w_col_next = r_col + CNT_WIDTH'(1);
    w_row_next = r_row;
    if (w_edge) begin
      w_col_next = '0;
      w_row_next = '0;
    end else if (r_col == COL_LAST) begin
      w_col_next = '0;
      w_row_next = (r_row == ROW_LAST) ? '0 : r_row + CNT_WIDTH'(1);
    end
  end

  assign w_active_next = ({1'b0, w_col_next} < ACT_COLS) &&
                         ({1'b0, w_row_next} < ACT_ROWS);

  // Lock FSM next-state, good/error counts and error pulse.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_errs_next  = r_errs;
    w_err_pulse  = 1'b0;
    unique case (r_state)
      ST_UNLOCKED: begin
        if (w_edge) begin
          w_state_next = ST_CHECK;
          w_good_next  = w_aligned ? GOOD_W'(1) : '0;
          w_errs_next  = '0;
        end
      end
      ST_CHECK: begin
        if (w_aligned) begin
          if (r_good >= GOOD_LAST) begin
            w_state_next = ST_LOCKED;
            w_good_next  = '0;
            w_errs_next  = '0;
          end else begin
            w_good_next = r_good + GOOD_W'(1);
          end
        end else if (w_misaligned) begin
          w_good_next = '0;
          w_err_pulse = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_aligned) begin
          w_errs_next = '0;
        end else if (w_misaligned || w_missing) begin
          w_err_pulse = 1'b1;
          if (r_errs >= ERRS_LAST) begin
            w_state_next = ST_UNLOCKED;
            w_errs_next  = '0;
          end else begin
            w_errs_next = r_errs + ERR_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_UNLOCKED;
        w_good_next  = '0;
        w_errs_next  = '0;
      end
    endcase
  end

  // Sync delay, counters and frame outputs all advance on the same edge.
  always_ff @(posedge clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_hsync       <= io_sync.i_HSync;
      r_vsync       <= io_sync.i_VSync;
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_active      <= w_active_next;
      r_frame_start <= w_edge;
      r_frame_cnt   <= r_frame_cnt + (w_edge ? FRAME_WIDTH'(1) : '0);
    end
  end

  // Lock FSM state register with registered status outputs.
  always_ff @(posedge clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= ST_UNLOCKED;
      r_good     <= '0;
      r_errs     <= '0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good     <= w_good_next;
      r_errs     <= w_errs_next;
      r_locked   <= (w_state_next == ST_LOCKED);
      r_sync_err <= w_err_pulse;
    end
  end

  assign io_sync.o_HSync       = r_hsync;
  assign io_sync.o_VSync       = r_vsync;
  assign io_sync.o_Col_Count   = r_col;
  assign io_sync.o_Row_Count   = r_row;
  assign io_sync.o_Active      = r_active;
  assign io_sync.o_Frame_Start = r_frame_start;
  assign io_sync.o_Frame_Count = r_frame_cnt;
  assign io_sync.o_Locked      = r_locked;
  assign io_sync.o_Sync_Err    = r_sync_err;

endmodule

// File: tb/tb_sync_lock_counter.sv
// Directed bench for sync_lock_counter: a 10x6 raster (60-cycle frames),
// rising-edge instance u_dut_r and a falling-edge, 2-bit frame count instance u_dut_f.
module tb_sync_lock_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_act  = 0;

  always #5 clk = ~clk;

  sync_lock_counter_if #(.CNT_WIDTH(4), .FRAME_WIDTH(8)) if_r ();
  sync_lock_counter_if #(.CNT_WIDTH(4), .FRAME_WIDTH(2)) if_f ();

  sync_lock_counter #(
    .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
    .CNT_WIDTH(4), .FRAME_WIDTH(8), .VSYNC_RISE(1'b1),
    .LOCK_FRAMES(2), .UNLOCK_ERRS(2)
  ) u_dut_r (
    .clk     (clk),
    .i_Rst   (rst),
    .io_sync (if_r.slave)
  );

  sync_lock_counter #(
    .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
    .CNT_WIDTH(4), .FRAME_WIDTH(2), .VSYNC_RISE(1'b0),
    .LOCK_FRAMES(2), .UNLOCK_ERRS(2)
  ) u_dut_f (
    .clk     (clk),
    .i_Rst   (rst),
    .io_sync (if_f.slave)
  );

  // Advance n clocks; land 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      $display("vec %0d %s obs=%0h exp=%0h ok", n_vec, tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle VSync pulse on the rising-edge instance; edge is taken on the next clock.
  task automatic edge_r();
    if_r.i_VSync = 1'b1;
    tick(1);
    if_r.i_VSync = 1'b0;
  endtask

  // One-cycle low pulse on the falling-edge instance.
  task automatic edge_f();
    if_f.i_VSync = 1'b0;
    tick(1);
    if_f.i_VSync = 1'b1;
  endtask

  initial begin
    if_r.i_HSync = 1'b0;
    if_r.i_VSync = 1'b0;
    if_f.i_HSync = 1'b0;
    if_f.i_VSync = 1'b1;

    // 1. Reset, free-run, asynchronous reset mid-count
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("s1_col5", 32'(if_r.o_Col_Count), 32'd5);
    if_r.i_HSync = 1'b1;
    tick(1);
    if_r.i_HSync = 1'b0;
    chk("s1_hsync_dly", 32'(if_r.o_HSync), 32'd1);
    chk("s1_active_c6", 32'(if_r.o_Active), 32'd1);
    rst = 1'b1;
    #1;
    chk("s1_rst_col", 32'(if_r.o_Col_Count), 32'd0);
    chk("s1_rst_row", 32'(if_r.o_Row_Count), 32'd0);
    chk("s1_rst_hsync", 32'(if_r.o_HSync), 32'd0);
    chk("s1_rst_active", 32'(if_r.o_Active), 32'd0);
    chk("s1_rst_locked", 32'(if_r.o_Locked), 32'd0);
    rst = 1'b0;
    tick(13);
    chk("s1_c13_col", 32'(if_r.o_Col_Count), 32'd3);
    chk("s1_c13_row", 32'(if_r.o_Row_Count), 32'd1);
    tick(46);
    chk("s1_c59_col", 32'(if_r.o_Col_Count), 32'd9);
    chk("s1_c59_row", 32'(if_r.o_Row_Count), 32'd5);
    chk("s1_c59_active", 32'(if_r.o_Active), 32'd0);
    tick(1);
    chk("s1_wrap_col", 32'(if_r.o_Col_Count), 32'd0);
    chk("s1_wrap_row", 32'(if_r.o_Row_Count), 32'd0);
    chk("s1_wrap_fs", 32'(if_r.o_Frame_Start), 32'd0);
    chk("s1_locked", 32'(if_r.o_Locked), 32'd0);

    // 2. Lock acquisition: misaligned first edge, then two aligned edges
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    edge_r();
    chk("s2_e1_col", 32'(if_r.o_Col_Count), 32'd0);
    chk("s2_e1_row", 32'(if_r.o_Row_Count), 32'd0);
    chk("s2_e1_vsync", 32'(if_r.o_VSync), 32'd1);
    chk("s2_e1_fs", 32'(if_r.o_Frame_Start), 32'd1);
    chk("s2_e1_fc", 32'(if_r.o_Frame_Count), 32'd1);
    chk("s2_e1_err", 32'(if_r.o_Sync_Err), 32'd0);
    chk("s2_e1_locked", 32'(if_r.o_Locked), 32'd0);
    tick(59);
    chk("s2_pre2_col", 32'(if_r.o_Col_Count), 32'd9);
    chk("s2_pre2_row", 32'(if_r.o_Row_Count), 32'd5);
    chk("s2_pre2_fs", 32'(if_r.o_Frame_Start), 32'd0);
    edge_r();
    chk("s2_e2_fs", 32'(if_r.o_Frame_Start), 32'd1);
    chk("s2_e2_fc", 32'(if_r.o_Frame_Count), 32'd2);
    chk("s2_e2_locked", 32'(if_r.o_Locked), 32'd0);
    tick(59);
    edge_r();
    chk("s2_e3_fc", 32'(if_r.o_Frame_Count), 32'd3);
    chk("s2_e3_locked", 32'(if_r.o_Locked), 32'd1);
    chk("s2_e3_err", 32'(if_r.o_Sync_Err), 32'd0);
    tick(1);
    chk("s2_fs_end", 32'(if_r.o_Frame_Start), 32'd0);

    // 3. Early edge while locked: one error, stay locked; aligned edge clears errors
    tick(51);
    edge_r();
    chk("s3_early_err", 32'(if_r.o_Sync_Err), 32'd1);
    chk("s3_early_locked", 32'(if_r.o_Locked), 32'd1);
    chk("s3_early_col", 32'(if_r.o_Col_Count), 32'd0);
    chk("s3_early_row", 32'(if_r.o_Row_Count), 32'd0);
    chk("s3_early_fc", 32'(if_r.o_Frame_Count), 32'd4);
    tick(1);
    chk("s3_err_end", 32'(if_r.o_Sync_Err), 32'd0);
    tick(58);
    edge_r();
    chk("s3_align_err", 32'(if_r.o_Sync_Err), 32'd0);
    chk("s3_align_fc", 32'(if_r.o_Frame_Count), 32'd5);
    tick(52);
    edge_r();
    chk("s3_early2_err", 32'(if_r.o_Sync_Err), 32'd1);
    chk("s3_early2_locked", 32'(if_r.o_Locked), 32'd1);
    tick(1);
    chk("s3_err2_end", 32'(if_r.o_Sync_Err), 32'd0);
    tick(58);
    edge_r();
    chk("s3_align2_fc", 32'(if_r.o_Frame_Count), 32'd7);
    chk("s3_align2_locked", 32'(if_r.o_Locked), 32'd1);

    // 4. VSync stops: error at each natural wrap, unlock after the second
    tick(59);
    chk("s4_pre_err", 32'(if_r.o_Sync_Err), 32'd0);
    chk("s4_pre_col", 32'(if_r.o_Col_Count), 32'd9);
    tick(1);
    chk("s4_miss1_err", 32'(if_r.o_Sync_Err), 32'd1);
    chk("s4_miss1_locked", 32'(if_r.o_Locked), 32'd1);
    chk("s4_miss1_fs", 32'(if_r.o_Frame_Start), 32'd0);
    tick(1);
    chk("s4_miss1_end", 32'(if_r.o_Sync_Err), 32'd0);
    tick(58);
    tick(1);
    chk("s4_miss2_err", 32'(if_r.o_Sync_Err), 32'd1);
    chk("s4_miss2_locked", 32'(if_r.o_Locked), 32'd0);
    tick(60);
    chk("s4_unl_err", 32'(if_r.o_Sync_Err), 32'd0);
    chk("s4_fc_hold", 32'(if_r.o_Frame_Count), 32'd7);

    // 5. Active sweep over one frame starting at (0,0)
    for (int j = 0; j < 60; j++) begin
      logic exp_act;
      exp_act = ((j % 10) < 8) && ((j / 10) < 4);
      chk($sformatf("s5_act_%0d", j), 32'(if_r.o_Active), 32'(exp_act));
      if (if_r.o_Active === 1'b1) n_act++;
      tick(1);
    end
    chk("s5_act_total", 32'(n_act), 32'd32);

    // 6. Falling-edge instance with 2-bit frame count
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s6_rst_fc", 32'(if_f.o_Frame_Count), 32'd0);
    tick(5);
    edge_f();
    chk("s6_e1_fc", 32'(if_f.o_Frame_Count), 32'd1);
    chk("s6_e1_col", 32'(if_f.o_Col_Count), 32'd0);
    chk("s6_e1_vsync", 32'(if_f.o_VSync), 32'd0);
    chk("s6_e1_locked", 32'(if_f.o_Locked), 32'd0);
    tick(59);
    edge_f();
    chk("s6_e2_fc", 32'(if_f.o_Frame_Count), 32'd2);
    chk("s6_e2_locked", 32'(if_f.o_Locked), 32'd0);
    tick(59);
    edge_f();
    chk("s6_e3_fc", 32'(if_f.o_Frame_Count), 32'd3);
    chk("s6_e3_locked", 32'(if_f.o_Locked), 32'd1);
    tick(59);
    edge_f();
    chk("s6_e4_fc_wrap", 32'(if_f.o_Frame_Count), 32'd0);
    chk("s6_e4_locked", 32'(if_f.o_Locked), 32'd1);
    chk("s6_e4_err", 32'(if_f.o_Sync_Err), 32'd0);
    tick(59);
    edge_f();
    chk("s6_e5_fc", 32'(if_f.o_Frame_Count), 32'd1);
    chk("s6_e5_fs", 32'(if_f.o_Frame_Start), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
